// File: rtl/fetch_unit_redirect_pkg.sv
// Shared types and defaults for the redirecting fetch unit.
// Buffer entries carry the instruction word with its PC.
package fetch_unit_redirect_pkg;

  localparam int unsigned SEQ_NUM_BITS  = 5;
  localparam int unsigned MAX_IN_FLIGHT = 4;
  localparam logic [31:0] RST_ADDR      = 32'h0000_0200;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_redirect_if.sv
// Memory, decode and squash signals of the fetch unit.
// master = fetch side, slave = memory/decode side.
interface fetch_unit_redirect_if #(
  parameter int unsigned SEQ_BITS =
    fetch_unit_redirect_pkg::SEQ_NUM_BITS
);

  logic                mem_req_val;
  logic                mem_req_rdy;
  logic [31:0]         mem_req_addr;
  logic                mem_resp_val;
  logic                mem_resp_rdy;
  logic [31:0]         mem_resp_data;
  logic                d_val;
  logic                d_rdy;
  logic [31:0]         d_inst;
  logic [31:0]         d_pc;
  logic [SEQ_BITS-1:0] d_seq_num;
  logic                squash_val;
  logic [31:0]         squash_target;
  logic [SEQ_BITS-1:0] squash_seq_num;

  modport master (
    output mem_req_val,
    output mem_req_addr,
    output mem_resp_rdy,
    output d_val,
    output d_inst,
    output d_pc,
    output d_seq_num,
    input  mem_req_rdy,
    input  mem_resp_val,
    input  mem_resp_data,
    input  d_rdy,
    input  squash_val,
    input  squash_target,
    input  squash_seq_num
  );

  modport slave (
    input  mem_req_val,
    input  mem_req_addr,
    input  mem_resp_rdy,
    input  d_val,
    input  d_inst,
    input  d_pc,
    input  d_seq_num,
    output mem_req_rdy,
    output mem_resp_val,
    output mem_resp_data,
    output d_rdy,
    output squash_val,
    output squash_target,
    output squash_seq_num
  );

endinterface

// File: rtl/fetch_unit_redirect_inst_buffer.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Flush dominates; push while full is accepted only with a pop.
module fetch_inst_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i &
                   (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit_redirect.sv
// In-order fetch stage: credit-limited requests, response buffer,
// squash redirect with discard of stale in-flight responses.
module fetch_unit_redirect
  import fetch_unit_redirect_pkg::*;
#(
  parameter logic [31:0] p_rst_addr      = RST_ADDR,
  parameter int unsigned p_seq_num_bits  = SEQ_NUM_BITS,
  parameter int unsigned p_max_in_flight = MAX_IN_FLIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_redirect_if.master io
);

  localparam int unsigned CW = $clog2(p_max_in_flight) + 1;

  logic [31:0]               pc_q, pc_d;
  logic [CW-1:0]             drop_q, drop_d;
  logic [p_seq_num_bits-1:0] seq_q, seq_d;

  logic [31:0]   tag_pc;
  logic          tag_full;
  logic          tag_empty_unused;
  logic [CW-1:0] tag_cnt;

  fetch_entry_t  buf_in;
  fetch_entry_t  buf_head;
  logic          buf_full_unused;
  logic          buf_empty;
  logic [CW-1:0] buf_cnt;

  logic [CW:0] occ;
  logic        req_ok;
  logic        req_fire;
  logic        resp_fire;
  logic        resp_keep;
  logic        d_ok;
  logic        d_fire;

  // Credit covers both in-flight requests and buffered entries.
  assign occ = {1'b0, tag_cnt} + {1'b0, buf_cnt};

  assign req_ok = rst & ~io.squash_val & ~tag_full &
                  (occ < (CW+1)'(p_max_in_flight));
  assign req_fire  = req_ok & io.mem_req_rdy;
  assign resp_fire = rst & io.mem_resp_val;
  assign resp_keep = resp_fire & ~io.squash_val &
                     (drop_q == '0);
  assign d_ok   = rst & ~buf_empty & ~io.squash_val;
  assign d_fire = d_ok & io.d_rdy;

  assign io.mem_req_val  = req_ok;
  assign io.mem_req_addr = pc_q;
  assign io.mem_resp_rdy = 1'b1;
  assign io.d_val        = d_ok;
  assign io.d_inst       = buf_head.inst;
  assign io.d_pc         = buf_head.pc;
  assign io.d_seq_num    = seq_q;

  assign buf_in = '{inst: io.mem_resp_data, pc: tag_pc};

  fetch_inst_buffer #(
    .DEPTH (p_max_in_flight),
    .WIDTH (32)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_fire),
    .pop_i   (resp_fire),
    .flush_i (1'b0),
    .data_i  (pc_q),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty_unused),
    .count_o (tag_cnt)
  );

  fetch_inst_buffer #(
    .DEPTH (p_max_in_flight),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (resp_keep),
    .pop_i   (d_fire),
    .flush_i (io.squash_val),
    .data_i  (buf_in),
    .data_o  (buf_head),
    .full_o  (buf_full_unused),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    seq_d  = seq_q;
    if (io.squash_val) begin
      // Everything still in flight after this edge is stale.
      pc_d   = io.squash_target;
      drop_d = tag_cnt - CW'(resp_fire);
      seq_d  = io.squash_seq_num + 1'b1;
    end else begin
      if (req_fire) pc_d = next_pc(pc_q);
      if (resp_fire && drop_q != '0)
        drop_d = drop_q - 1'b1;
      if (d_fire) seq_d = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= p_rst_addr;
      drop_q <= '0;
      seq_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      seq_q  <= seq_d;
    end
  end

endmodule
